// File: rtl/matmul_operand_feeder.sv
// matmul_operand_feeder
//
// Upstream stage of the systolic matmul calculator. Captures the full A and B
// operand matrices on a start request and replays them diagonally skewed, one
// wavefront per clock, onto the array's left (A) and top (B) edge buses. It
// issues the array's start_bit pulse and then holds busy until the array
// reports done, so a new product cannot be launched over one in flight.
//
// Ports
//   clk_i        single clock, rising edge
//   rst_ni       synchronous reset, active HIGH despite the name
//   start_i      capture a_mat_i/b_mat_i and launch (accepted in IDLE only)
//   a_mat_i      A, row-major, A[r][c] at element index r*N+c
//   b_mat_i      B, same packing
//   done_i       completion strobe from the array
//   a_o          lane i feeds array row i
//   b_o          lane j feeds array column j
//   start_bit_o  one-cycle launch pulse to the array
//   busy_o       product in flight; start_i is dropped while high
//   done_o       one-cycle pulse, array result valid
//   step_o       current feed step t (2N-1 while waiting for the array)
module matmul_operand_feeder #(
  parameter int BUS_WIDTH  = 16,
  parameter int DATA_WIDTH = 8
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic                                  start_i,
  input  logic [DATA_WIDTH*(BUS_WIDTH/DATA_WIDTH)*(BUS_WIDTH/DATA_WIDTH)-1:0] a_mat_i,
  input  logic [DATA_WIDTH*(BUS_WIDTH/DATA_WIDTH)*(BUS_WIDTH/DATA_WIDTH)-1:0] b_mat_i,
  input  logic                                  done_i,
  output logic [BUS_WIDTH-1:0]                  a_o,
  output logic [BUS_WIDTH-1:0]                  b_o,
  output logic                                  start_bit_o,
  output logic                                  busy_o,
  output logic                                  done_o,
  output logic [$clog2(2*(BUS_WIDTH/DATA_WIDTH))-1:0] step_o
);

  localparam int MAX_DIM = BUS_WIDTH / DATA_WIDTH;
  localparam int N       = MAX_DIM;
  localparam int DW      = DATA_WIDTH;
  localparam int MAT_W   = DW * N * N;
  localparam int STEP_W  = $clog2(2 * N);
  localparam int LAST_T  = 2 * N - 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FEED,
    S_WAIT
  } state_t;

  state_t                r_state;
  logic [MAT_W-1:0]      r_a_mat;
  logic [MAT_W-1:0]      r_b_mat;
  logic [BUS_WIDTH-1:0]  r_a_o;
  logic [BUS_WIDTH-1:0]  r_b_o;
  logic                  r_start_bit;
  logic                  r_busy;
  logic                  r_done;
  logic [STEP_W-1:0]     r_step;

  // Wavefront t on the A edge: row i carries A[i][t-i] while that column exists.
  function automatic logic [BUS_WIDTH-1:0] skew_a(input logic [MAT_W-1:0] m, input int t);
    logic [BUS_WIDTH-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) begin
      int c;
      c = t - i;
      if (c >= 0 && c < N) v[i*DW +: DW] = m[(i*N + c)*DW +: DW];
    end
    return v;
  endfunction

  // Wavefront t on the B edge: column j carries B[t-j][j] while that row exists.
  function automatic logic [BUS_WIDTH-1:0] skew_b(input logic [MAT_W-1:0] m, input int t);
    logic [BUS_WIDTH-1:0] v;
    v = '0;
    for (int j = 0; j < N; j++) begin
      int r;
      r = t - j;
      if (r >= 0 && r < N) v[j*DW +: DW] = m[(r*N + j)*DW +: DW];
    end
    return v;
  endfunction

  // Outputs are registered one step ahead: the t=0 wavefront is built from the
  // live inputs at the capture edge, later ones from the captured copy.
  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      r_state     <= S_IDLE;
      r_a_mat     <= '0;
      r_b_mat     <= '0;
      r_a_o       <= '0;
      r_b_o       <= '0;
      r_start_bit <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_step      <= '0;
    end else begin
      r_start_bit <= 1'b0;
      r_done      <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_a_o  <= '0;
          r_b_o  <= '0;
          r_busy <= 1'b0;
          r_step <= '0;
          if (start_i) begin
            r_a_mat     <= a_mat_i;
            r_b_mat     <= b_mat_i;
            r_a_o       <= skew_a(a_mat_i, 0);
            r_b_o       <= skew_b(b_mat_i, 0);
            r_start_bit <= 1'b1;
            r_busy      <= 1'b1;
            r_state     <= S_FEED;
          end
        end
        S_FEED: begin
          if (int'(r_step) == LAST_T) begin
            r_a_o   <= '0;
            r_b_o   <= '0;
            r_step  <= STEP_W'(2 * N - 1);
            r_state <= S_WAIT;
          end else begin
            r_a_o  <= skew_a(r_a_mat, int'(r_step) + 1);
            r_b_o  <= skew_b(r_b_mat, int'(r_step) + 1);
            r_step <= r_step + 1'b1;
          end
        end
        S_WAIT: begin
          if (done_i) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_step  <= '0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign a_o         = r_a_o;
  assign b_o         = r_b_o;
  assign start_bit_o = r_start_bit;
  assign busy_o      = r_busy;
  assign done_o      = r_done;
  assign step_o      = r_step;

endmodule

// File: tb/tb_matmul_operand_feeder.sv
// Bench for matmul_operand_feeder: directed vectors with literal expectations,
// plus a wavefront model checked against the DUT on every cycle.
module tb_matmul_operand_feeder;

  localparam int BW = 16;
  localparam int DW = 8;
  localparam int N  = BW / DW;
  localparam int SW = $clog2(2 * N);
  localparam int MW = DW * N * N;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [MW-1:0] amat = '0;
  logic [MW-1:0] bmat = '0;
  logic          done_in = 1'b0;
  logic [BW-1:0] a_o, b_o;
  logic          start_bit_o, busy_o, done_o;
  logic [SW-1:0] step_o;

  int n_vec = 0;
  int n_err = 0;

  matmul_operand_feeder #(.BUS_WIDTH(BW), .DATA_WIDTH(DW)) dut (
    .clk_i(clk), .rst_ni(rst), .start_i(start), .a_mat_i(amat), .b_mat_i(bmat),
    .done_i(done_in), .a_o(a_o), .b_o(b_o), .start_bit_o(start_bit_o),
    .busy_o(busy_o), .done_o(done_o), .step_o(step_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  // mt: -1 idle, 0..2N-2 feed step, 2N-1 waiting for the array.
  int         mt = -1;
  bit         m_done = 1'b0;
  bit         live = 1'b0;
  logic [7:0] mA [N][N];
  logic [7:0] mB [N][N];

  always @(posedge clk) begin
    live = 1'b1;
    m_done = 1'b0;
    if (rst) begin
      mt = -1;
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++) begin
          mA[r][c] = '0;
          mB[r][c] = '0;
        end
    end else if (mt < 0) begin
      if (start) begin
        for (int r = 0; r < N; r++)
          for (int c = 0; c < N; c++) begin
            mA[r][c] = amat[(r*N+c)*DW +: DW];
            mB[r][c] = bmat[(r*N+c)*DW +: DW];
          end
        mt = 0;
      end
    end else if (mt < 2*N-1) begin
      mt = mt + 1;
    end else if (done_in) begin
      mt = -1;
      m_done = 1'b1;
    end
  end

  function automatic logic [BW-1:0] exp_a();
    logic [BW-1:0] v;
    v = '0;
    if (mt >= 0 && mt <= 2*N-2)
      for (int i = 0; i < N; i++)
        if (mt - i >= 0 && mt - i < N) v[i*DW +: DW] = mA[i][mt-i];
    return v;
  endfunction

  function automatic logic [BW-1:0] exp_b();
    logic [BW-1:0] v;
    v = '0;
    if (mt >= 0 && mt <= 2*N-2)
      for (int j = 0; j < N; j++)
        if (mt - j >= 0 && mt - j < N) v[j*DW +: DW] = mB[mt-j][j];
    return v;
  endfunction

  always @(negedge clk) begin
    if (live) begin
      chk("model a_o", 32'(a_o), 32'(exp_a()));
      chk("model b_o", 32'(b_o), 32'(exp_b()));
      chk("model start_bit_o", 32'(start_bit_o), 32'(mt == 0));
      chk("model busy_o", 32'(busy_o), 32'(mt >= 0));
      chk("model done_o", 32'(done_o), 32'(m_done));
      chk("model step_o", 32'(step_o), (mt < 0) ? 32'd0 : 32'(mt));
    end
  end

  // ---------------- directed stimulus ----------------
  localparam logic [MW-1:0] EX_A = 32'h04030201; // [[1,2],[3,4]]
  localparam logic [MW-1:0] EX_B = 32'h08070605; // [[5,6],[7,8]]

  initial begin
    // Reset for two edges with start_i asserted: must be ignored.
    rst = 1'b1; start = 1'b1; amat = EX_A; bmat = EX_B;
    @(negedge clk);
    @(negedge clk);
    chk("reset a_o", 32'(a_o), 32'h0);
    chk("reset busy_o", 32'(busy_o), 32'h0);
    chk("reset start_bit_o", 32'(start_bit_o), 32'h0);
    chk("reset step_o", 32'(step_o), 32'h0);

    // Launch the worked example.
    rst = 1'b0; start = 1'b1;
    @(negedge clk);
    chk("t0 a_o", 32'(a_o), 32'h0001);
    chk("t0 b_o", 32'(b_o), 32'h0005);
    chk("t0 start_bit_o", 32'(start_bit_o), 32'h1);
    // Lockout: new matrices and done_i while feeding.
    start = 1'b1; amat = 32'hAABBCCDD; bmat = 32'h11223344; done_in = 1'b1;
    @(negedge clk);
    chk("t1 a_o", 32'(a_o), 32'h0302);
    chk("t1 b_o", 32'(b_o), 32'h0607);
    chk("t1 start_bit_o", 32'(start_bit_o), 32'h0);
    @(negedge clk);
    chk("t2 a_o", 32'(a_o), 32'h0400);
    chk("t2 b_o", 32'(b_o), 32'h0800);
    start = 1'b0; done_in = 1'b0;
    @(negedge clk);
    chk("wait a_o", 32'(a_o), 32'h0);
    chk("wait step_o", 32'(step_o), 32'h3);
    chk("wait busy_o", 32'(busy_o), 32'h1);
    @(negedge clk);
    chk("wait hold busy_o", 32'(busy_o), 32'h1);
    done_in = 1'b1;
    @(negedge clk);
    chk("done done_o", 32'(done_o), 32'h1);
    chk("done busy_o", 32'(busy_o), 32'h0);
    // Back-to-back: start in the done_o cycle.
    done_in = 1'b0; start = 1'b1; amat = 32'h40302010; bmat = 32'h80706050;
    @(negedge clk);
    chk("done drop", 32'(done_o), 32'h0);
    chk("b2b t0 a_o", 32'(a_o), 32'h0010);
    chk("b2b t0 start_bit_o", 32'(start_bit_o), 32'h1);
    start = 1'b0;
    @(negedge clk);
    // Abort during t1.
    rst = 1'b1;
    @(negedge clk);
    chk("abort a_o", 32'(a_o), 32'h0);
    chk("abort busy_o", 32'(busy_o), 32'h0);
    rst = 1'b0; done_in = 1'b1;
    @(negedge clk);
    chk("abort no done_o", 32'(done_o), 32'h0);
    done_in = 1'b0; start = 1'b1; amat = EX_A; bmat = EX_B;
    @(negedge clk);
    chk("relaunch t0 a_o", 32'(a_o), 32'h0001);
    chk("relaunch t0 b_o", 32'(b_o), 32'h0005);
    start = 1'b0;
    repeat (2*N) @(negedge clk);
    done_in = 1'b1;
    @(negedge clk);
    done_in = 1'b0;
    @(negedge clk);

    // Mixed launches with varying matrices, stray done_i and wait lengths.
    for (int k = 0; k < 8; k++) begin
      start = 1'b1; amat = MW'($urandom); bmat = MW'($urandom);
      @(negedge clk);
      start = 1'b0;
      for (int s = 0; s < 2*N - 1; s++) begin
        done_in = 1'($urandom_range(0, 1));
        start   = 1'($urandom_range(0, 1));
        @(negedge clk);
      end
      done_in = 1'b0; start = 1'b0;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      done_in = 1'b1;
      @(negedge clk);
      done_in = 1'b0;
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
